// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control sequencer for the 8-bit, 32-entry
// register-file datapath. Fetches 32-bit words over a req/ack handshake,
// decodes ADDU/SUBU/ADDIU and walks FETCH, DECODE, READ, EXEC, WB per
// instruction, running PC 0 .. max_pc-1 and then parking in DONE.
//
// Optional feature: define ILLEGAL_TRAP_EN to halt in TRAP on an illegal
// instruction. Left undefined, illegal words execute as NOPs and trap is 0.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start, max_pc      begin a run of max_pc instructions (IDLE/DONE only)
//   imem_req/addr      fetch request and address (= pc)
//   imem_ack/data      fetch accept, instruction word valid with ack
//   rf_re, rf_ra1/2    register-file read strobe and read addresses
//   alu_en, alu_op     ALU evaluate strobe, op (00 none, 01 add, 10 sub)
//   alu_src_imm, imm   immediate operand select and immediate (ir[7:0])
//   rf_we, rf_wa       write-back strobe and write address
//   busy, done, trap   run in progress, run complete, illegal-instr halt
module mc_sequencer #(
    parameter int unsigned PC_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] max_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic            rf_re,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    output logic            alu_en,
    output logic [1:0]      alu_op,
    output logic            alu_src_imm,
    output logic [7:0]      imm,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic            busy,
    output logic            done,
    output logic            trap
);

    localparam int unsigned CMP_W = PC_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        READ   = 3'd3,
        EXEC   = 3'd4,
        WB     = 3'd5,
        DONE   = 3'd6
`ifdef ILLEGAL_TRAP_EN
        , TRAP = 3'd7
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc, pc_d;
    logic [PC_W-1:0] max_q, max_d;
    logic [31:0]     ir, ir_d;
    logic            legal, legal_d;
    logic [4:0]      ra1_d, ra2_d, wa_d;
    logic [1:0]      op_d;
    logic            src_d;
    logic [7:0]      imm_d;
    logic [CMP_W-1:0] pc_inc;
    logic [5:0]      opcode, funct;

    // Shamt bits carry no meaning for the supported instructions.
    logic unused_shamt;
    assign unused_shamt = ^ir[10:8];

    assign imem_addr = pc;
    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];

    // Next-state, datapath register and decoded-field logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        max_d   = max_q;
        ir_d    = ir;
        legal_d = legal;
        ra1_d   = rf_ra1;
        ra2_d   = rf_ra2;
        wa_d    = rf_wa;
        op_d    = alu_op;
        src_d   = alu_src_imm;
        imm_d   = imm;
        // One extra bit so the end-of-run compare never sees a wrapped pc.
        pc_inc  = CMP_W'(pc) + CMP_W'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pc_d    = '0;
                    max_d   = max_pc;
                    state_d = (max_pc == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                legal_d = 1'b0;
                ra1_d   = '0;
                ra2_d   = '0;
                wa_d    = '0;
                op_d    = 2'b00;
                src_d   = 1'b0;
                imm_d   = ir[7:0];
                if (opcode == 6'b000000 && funct == 6'b100001) begin
                    legal_d = 1'b1;
                    op_d    = 2'b01;
                    ra1_d   = ir[25:21];
                    ra2_d   = ir[20:16];
                    wa_d    = ir[15:11];
                end else if (opcode == 6'b000000 && funct == 6'b100011) begin
                    legal_d = 1'b1;
                    op_d    = 2'b10;
                    ra1_d   = ir[25:21];
                    ra2_d   = ir[20:16];
                    wa_d    = ir[15:11];
                end else if (opcode == 6'b001001) begin
                    legal_d = 1'b1;
                    op_d    = 2'b01;
                    src_d   = 1'b1;
                    ra1_d   = ir[25:21];
                    wa_d    = ir[20:16];
                end
                state_d = READ;
            end
            READ: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d = WB;
`ifdef ILLEGAL_TRAP_EN
                if (!legal) begin
                    state_d = TRAP;
                end
`endif
            end
            WB: begin
                pc_d    = pc_inc[PC_W-1:0];
                state_d = (pc_inc < CMP_W'(max_q)) ? FETCH : DONE;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath registers and Moore outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc          <= '0;
            max_q       <= '0;
            ir          <= '0;
            legal       <= 1'b0;
            rf_ra1      <= '0;
            rf_ra2      <= '0;
            rf_wa       <= '0;
            alu_op      <= 2'b00;
            alu_src_imm <= 1'b0;
            imm         <= '0;
            imem_req    <= 1'b0;
            rf_re       <= 1'b0;
            alu_en      <= 1'b0;
            rf_we       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            max_q       <= max_d;
            ir          <= ir_d;
            legal       <= legal_d;
            rf_ra1      <= ra1_d;
            rf_ra2      <= ra2_d;
            rf_wa       <= wa_d;
            alu_op      <= op_d;
            alu_src_imm <= src_d;
            imm         <= imm_d;
            imem_req    <= (state_d == FETCH);
            rf_re       <= (state_d == READ);
            alu_en      <= (state_d == EXEC);
            rf_we       <= (state_d == WB) && legal_d && (wa_d != 5'd0);
            busy        <= (state_d == FETCH) || (state_d == DECODE) ||
                           (state_d == READ)  || (state_d == EXEC)   ||
                           (state_d == WB);
            done        <= (state_d == DONE);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap <= 1'b0;
        end else begin
            trap <= (state_d == TRAP);
        end
    end
`else
    assign trap = 1'b0;
`endif

endmodule
